// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight register producers after D and
// the multiply/divide unit, producing the D-stage stall and forwarding selects.
module hazard_scoreboard #(
  parameter int unsigned NSTAGE   = 3,
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic       d_wr_en,
  input  logic [4:0] d_wr_addr,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_is_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic [1:0] fwd_rs,
  output logic [1:0] fwd_rt,
  output logic       md_busy
);

  localparam int unsigned MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);
  localparam logic [1:0]  TUSE_NONE = 2'd3;

  logic [NSTAGE-1:0] valid_q, valid_d;
  logic [4:0]        addr_q [NSTAGE];
  logic [4:0]        addr_d [NSTAGE];
  logic [1:0]        tnew_q [NSTAGE];
  logic [1:0]        tnew_d [NSTAGE];
  logic [CW-1:0]     cnt_q, cnt_d;

  logic       hit_rs, hit_rt;
  logic [1:0] tnew_rs, tnew_rt;
  logic [1:0] src_rs, src_rt;
  logic       haz_rs, haz_rt, haz_md;

  assign md_busy = (cnt_q != '0);

  // Youngest-match lookup: scan oldest to youngest so the youngest hit wins.
  always_comb begin
    hit_rs  = 1'b0;
    hit_rt  = 1'b0;
    tnew_rs = 2'd0;
    tnew_rt = 2'd0;
    src_rs  = 2'd0;
    src_rt  = 2'd0;
    for (int k = int'(NSTAGE) - 1; k >= 0; k--) begin
      if (valid_q[k] && (addr_q[k] == d_rs) && (d_rs != 5'd0)) begin
        hit_rs  = 1'b1;
        tnew_rs = tnew_q[k];
        src_rs  = 2'(k + 1);
      end
      if (valid_q[k] && (addr_q[k] == d_rt) && (d_rt != 5'd0)) begin
        hit_rt  = 1'b1;
        tnew_rt = tnew_q[k];
        src_rt  = 2'(k + 1);
      end
    end
  end

  // Hazard detection and forwarding selects; forced quiet while in reset.
  always_comb begin
    haz_rs = hit_rs && (d_tuse_rs != TUSE_NONE) && (tnew_rs > d_tuse_rs);
    haz_rt = hit_rt && (d_tuse_rt != TUSE_NONE) && (tnew_rt > d_tuse_rt);
    haz_md = (d_md_start || d_md_use) && md_busy;
    stall  = !reset && (haz_rs || haz_rt || haz_md);
    fwd_rs = (!reset && hit_rs && (tnew_rs == 2'd0)) ? src_rs : 2'd0;
    fwd_rt = (!reset && hit_rt && (tnew_rt == 2'd0)) ? src_rt : 2'd0;
  end

  // Next state: shift the producer pipe and run the MDU counter.
  always_comb begin
    valid_d    = '0;
    valid_d[0] = !stall && d_wr_en && (d_wr_addr != 5'd0);
    addr_d[0]  = d_wr_addr;
    tnew_d[0]  = d_tnew;
    for (int k = 1; k < int'(NSTAGE); k++) begin
      valid_d[k] = valid_q[k-1];
      addr_d[k]  = addr_q[k-1];
      tnew_d[k]  = (tnew_q[k-1] == 2'd0) ? 2'd0 : tnew_q[k-1] - 2'd1;
    end

    cnt_d = cnt_q;
    if (d_md_start && !stall) begin
      cnt_d = d_md_is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int k = 0; k < int'(NSTAGE); k++) begin
        addr_q[k] <= 5'd0;
        tnew_q[k] <= 2'd0;
      end
      cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < int'(NSTAGE); k++) begin
        addr_q[k] <= addr_d[k];
        tnew_q[k] <= tnew_d[k];
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scenario bench for hazard_scoreboard; expected {stall,fwd_rs,fwd_rt,md_busy}
// words are queued as each cycle is driven and popped when the outputs settle.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_wr_addr;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_wr_en, d_md_start, d_md_is_div, d_md_use;
  logic       stall, md_busy;
  logic [1:0] fwd_rs, fwd_rt;

  logic [5:0] exp_q[$];
  logic [5:0] got, e;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NSTAGE(3), .MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_is_div(d_md_is_div), .d_md_use(d_md_use),
    .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .md_busy(md_busy)
  );

  task automatic idle();
    d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
    d_wr_en = 1'b0; d_wr_addr = 5'd0; d_tnew = 2'd0;
    d_md_start = 1'b0; d_md_is_div = 1'b0; d_md_use = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [1:0] t);
    d_wr_en = 1'b1; d_wr_addr = a; d_tnew = t;
  endtask

  task automatic rd(input logic [4:0] rs, input logic [1:0] us,
                    input logic [4:0] rt, input logic [1:0] ut);
    d_rs = rs; d_tuse_rs = us; d_rt = rt; d_tuse_rt = ut;
  endtask

  task automatic flush();
    repeat (12) begin
      @(negedge clk);
      idle();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      idle();
      reset = (i == 0);
      rd(5'd3, 2'd0, 5'd3, 2'd0);
      exp_q.push_back(6'b0_00_00_0);
      #1 got = {stall, fwd_rs, fwd_rt, md_busy};
      e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL reset c%0d got=%b exp=%b", i, got, e); end
    end
  endtask

  // lw $3 then add reading $3 in E: one stall, then $3 sits in M with tnew=1.
  task automatic test_load_use();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle();
      case (i)
        0: begin wr(5'd3, 2'd2); exp_q.push_back(6'b0_00_00_0); end
        1: begin rd(5'd3, 2'd1, 5'd0, 2'd3); wr(5'd4, 2'd1); exp_q.push_back(6'b1_00_00_0); end
        2: begin rd(5'd3, 2'd1, 5'd0, 2'd3); wr(5'd4, 2'd1); exp_q.push_back(6'b0_00_00_0); end
        default: begin rd(5'd3, 2'd0, 5'd0, 2'd3); exp_q.push_back(6'b0_11_00_0); end
      endcase
      #1 got = {stall, fwd_rs, fwd_rt, md_busy};
      e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL load_use c%0d got=%b exp=%b", i, got, e); end
    end
    flush();
  endtask

  task automatic test_alu_branch();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      if (i == 0) begin
        wr(5'd5, 2'd1); exp_q.push_back(6'b0_00_00_0);
      end else begin
        rd(5'd5, 2'd0, 5'd0, 2'd0);
        exp_q.push_back((i == 1) ? 6'b1_00_00_0 : 6'b0_10_00_0);
      end
      #1 got = {stall, fwd_rs, fwd_rt, md_busy};
      e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL alu_branch c%0d got=%b exp=%b", i, got, e); end
    end
    flush();
  endtask

  task automatic test_zero_reg();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle();
      if (i < 3) wr(5'd0, 2'(i));
      rd(5'd0, 2'd0, 5'd0, 2'd0);
      exp_q.push_back(6'b0_00_00_0);
      #1 got = {stall, fwd_rs, fwd_rt, md_busy};
      e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL zero_reg c%0d got=%b exp=%b", i, got, e); end
    end
    flush();
  endtask

  // Two back-to-back producers of one register: only the younger is consulted.
  task automatic test_youngest();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        idle();
        case (i)
          0: begin wr((p == 0) ? 5'd7 : 5'd10, 2'd0); exp_q.push_back(6'b0_00_00_0); end
          1: begin wr((p == 0) ? 5'd7 : 5'd10, (p == 0) ? 2'd0 : 2'd2); exp_q.push_back(6'b0_00_00_0); end
          default: begin
            if (p == 0) begin rd(5'd7, 2'd1, 5'd9, 2'd1); exp_q.push_back(6'b0_01_00_0); end
            else begin rd(5'd10, 2'd1, 5'd0, 2'd3); exp_q.push_back(6'b1_00_00_0); end
          end
        endcase
        #1 got = {stall, fwd_rs, fwd_rt, md_busy};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL youngest p%0d c%0d got=%b exp=%b", p, i, got, e); end
      end
      flush();
    end
  endtask

  task automatic test_both_operands();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle();
      if (i == 0) begin
        wr(5'd6, 2'd2); exp_q.push_back(6'b0_00_00_0);
      end else begin
        rd(5'd6, 2'd0, 5'd6, 2'd0);
        exp_q.push_back((i < 3) ? 6'b1_00_00_0 : 6'b0_11_11_0);
      end
      #1 got = {stall, fwd_rs, fwd_rt, md_busy};
      e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL both_ops c%0d got=%b exp=%b", i, got, e); end
    end
    flush();
  endtask

  task automatic test_independent();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      case (i)
        0: begin wr(5'd8, 2'd1); exp_q.push_back(6'b0_00_00_0); end
        1: begin wr(5'd9, 2'd0); exp_q.push_back(6'b0_00_00_0); end
        default: begin rd(5'd9, 2'd1, 5'd8, 2'd1); exp_q.push_back(6'b0_01_10_0); end
      endcase
      #1 got = {stall, fwd_rs, fwd_rt, md_busy};
      e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL independent c%0d got=%b exp=%b", i, got, e); end
    end
    flush();
  endtask

  // div at cycle 0, mfhi waits in D through cycle 10, accepted at 11.
  task automatic test_div();
    for (int i = 0; i <= 11; i++) begin
      @(negedge clk);
      idle();
      if (i == 0) begin
        d_md_start = 1'b1; d_md_is_div = 1'b1; exp_q.push_back(6'b0_00_00_0);
      end else begin
        d_md_use = 1'b1;
        exp_q.push_back((i <= 10) ? 6'b1_00_00_1 : 6'b0_00_00_0);
      end
      #1 got = {stall, fwd_rs, fwd_rt, md_busy};
      e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL div c%0d got=%b exp=%b", i, got, e); end
    end
    flush();
  endtask

  // mult busy 1..5; a second start at cycle 3 stalls and must not reload.
  task automatic test_mult();
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      idle();
      d_md_start = (i == 0) || (i == 3);
      if (i == 3) exp_q.push_back(6'b1_00_00_1);
      else exp_q.push_back({5'b0, (i >= 1 && i <= 5)});
      #1 got = {stall, fwd_rs, fwd_rt, md_busy};
      e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL mult c%0d got=%b exp=%b", i, got, e); end
    end
    flush();
  endtask

  // Reset at cycle 4 of a mult, with a start and a ready $2 producer in flight.
  task automatic test_reset_mid();
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      idle();
      reset = (i == 4);
      case (i)
        0: begin d_md_start = 1'b1; exp_q.push_back(6'b0_00_00_0); end
        1, 2: exp_q.push_back(6'b0_00_00_1);
        3: begin wr(5'd2, 2'd0); exp_q.push_back(6'b0_00_00_1); end
        4: d_md_start = 1'b1;
        5: begin rd(5'd2, 2'd0, 5'd2, 2'd0); d_md_use = 1'b1; exp_q.push_back(6'b0_00_00_0); end
        default: begin d_md_use = 1'b1; exp_q.push_back(6'b0_00_00_0); end
      endcase
      if (i != 4) begin
        #1 got = {stall, fwd_rs, fwd_rt, md_busy};
        e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL reset_mid c%0d got=%b exp=%b", i, got, e); end
      end
    end
    @(negedge clk);
    reset = 1'b0;
    flush();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_alu_branch();
    test_zero_reg();
    test_youngest();
    test_both_operands();
    test_independent();
    test_div();
    test_mult();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
